clk_enable_ctrl: RTL
====================

CLK_ENABLE_CTRL -- requirements
Module: clk_enable_ctrl

Interface
REQ-001 Parameter DIV_W, default 24, width of the slow-run prescaler and of slow_div.
REQ-002 Parameter DB_CYCLES, default 16, number of consecutive stable samples a button needs before its debounced level changes.
REQ-003 clk  in  1  single system clock, taken from the global clock buffer; the block has exactly one clock.
REQ-004 rst  in  1  reset, synchronous to clk, active-high.
REQ-005 run_btn  in  1  asynchronous run/halt toggle button, active-high.
REQ-006 step_btn  in  1  asynchronous single-step button, active-high.
REQ-007 halt_req  in  1  synchronous CPU halt request (HLT executed), level.
REQ-008 mode_slow  in  1  when high, RUN issues throttled enables.
REQ-009 slow_div  in  DIV_W  slow-run period minus one, in clk cycles.
REQ-010 cpu_ce  out  1  CPU clock enable; the CPU advances one instruction cycle per high clk cycle.
REQ-011 running  out  1  high while the FSM is in RUN.
REQ-012 halted  out  1  high while the FSM is in HALT.
REQ-013 cycle_cnt  out  16  count of cpu_ce pulses issued.

Function
REQ-014 Each button: 2-flop synchroniser; then a debouncer in which the debounced level takes the synchronised value after it has been equal for DB_CYCLES consecutive cycles; then a rising-edge detector producing a 1-cycle event (run_evt, step_evt).
REQ-015 Button latency: press held stable -> event asserted exactly 2+DB_CYCLES+1 cycles after the first clk edge that samples it high; release produces no event.
REQ-016 FSM states HALT, RUN, STEP; the reset state is HALT.
REQ-017 HALT: cpu_ce=0; step_evt -> STEP; run_evt -> RUN; both asserted together -> RUN.
REQ-018 STEP: cpu_ce=1 for exactly one cycle, then unconditionally HALT; button events in STEP are dropped.
REQ-019 RUN with mode_slow=0: cpu_ce=1 every cycle.
REQ-020 RUN with mode_slow=1: the prescaler counts 0..slow_div and cpu_ce=1 in the cycle the count equals slow_div, then the count returns to 0; slow_div=0 yields cpu_ce every cycle.
REQ-021 The prescaler is held at 0 outside RUN; on RUN entry the first slow pulse comes slow_div+1 cycles after entry.
REQ-022 RUN -> HALT on run_evt or halt_req; cpu_ce is forced 0 in that same cycle.
REQ-023 halt_req has priority over every other event; in HALT, halt_req is ignored.
REQ-024 A change of slow_div during RUN takes effect at the next comparison; a count already above the new slow_div wraps to 0 on the next cycle without a pulse.
REQ-025 cycle_cnt increments on every cycle with cpu_ce=1 and wraps from 0xFFFF to 0x0000.
REQ-026 running and halted are registered state decodes; neither is high in STEP.

Reset
REQ-027 Reset values: cpu_ce=0, running=0, halted=1, cycle_cnt=0, FSM=HALT, prescaler=0, debounced levels=0, synchronisers=0.
REQ-028 Reset asserted mid-RUN or mid-STEP forces cpu_ce=0 in the next cycle and discards pending events.

Structure
REQ-029 A shared package holds the state enum (HALT, RUN, STEP) and the default DB_CYCLES and DIV_W constants.
REQ-030 One sub-module, btn_debounce (synchroniser + debouncer + edge detector), is instantiated twice.

Verification
REQ-031 Reset, then step_btn held 20 cycles (DB_CYCLES=4) -> exactly one cpu_ce pulse 7 cycles after press, halted back to 1, cycle_cnt=1.
REQ-032 run_btn press, mode_slow=0 -> running=1, cpu_ce high continuously; after 100 enables, halt_req=1 -> cpu_ce=0 that cycle, halted=1, cycle_cnt=100.
REQ-033 mode_slow=1, slow_div=3, RUN -> cpu_ce pulses every 4th cycle, first pulse 4 cycles after entry.
REQ-034 Button bounce of 1-cycle glitches for 30 cycles (DB_CYCLES=4) -> no event; a stable level afterwards -> exactly one event.
REQ-035 cycle_cnt preloaded by running 65535 enables, then one more -> cycle_cnt=0x0000.
REQ-036 run_evt and halt_req in the same RUN cycle -> HALT, cpu_ce=0; rst mid-RUN -> next cycle cpu_ce=0, halted=1, cycle_cnt=0.

Source files
------------

// File: rtl/clk_enable_ctrl_pkg.sv
// rtl/clk_enable_ctrl_pkg.sv - shared state encoding and default sizes for the CPU clock-enable controller
package clk_enable_ctrl_pkg;

    localparam int DEF_DIV_W     = 24;
    localparam int DEF_DB_CYCLES = 16;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_e;

endpackage

// File: rtl/clk_enable_ctrl_if.sv
// rtl/clk_enable_ctrl_if.sv - front-panel/CPU signal bundle between the control source and the enable controller
interface clk_enable_ctrl_if
    import clk_enable_ctrl_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) ();

    logic             run_btn;
    logic             step_btn;
    logic             halt_req;
    logic             mode_slow;
    logic [DIV_W-1:0] slow_div;
    logic             cpu_ce;
    logic             running;
    logic             halted;
    logic [15:0]      cycle_cnt;

    modport master (
        output run_btn, step_btn, halt_req, mode_slow, slow_div,
        input  cpu_ce, running, halted, cycle_cnt
    );

    modport slave (
        input  run_btn, step_btn, halt_req, mode_slow, slow_div,
        output cpu_ce, running, halted, cycle_cnt
    );

endinterface

// File: rtl/clk_enable_ctrl_btn_debounce.sv
// rtl/clk_enable_ctrl_btn_debounce.sv - button synchroniser, stability debouncer and rising-edge event
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic evt
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] stable_cnt;

    // stable_cnt counts consecutive samples that disagree with the current level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            level      <= 1'b0;
            level_d    <= 1'b0;
            evt        <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_1  <= btn;
            sync_2  <= sync_1;
            level_d <= level;
            evt     <= level & ~level_d;
            if (sync_2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DB_CYCLES - 1)) begin
                level      <= sync_2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_enable_ctrl.sv
// rtl/clk_enable_ctrl.sv - HALT/RUN/STEP controller issuing the CPU clock enable with optional slow-run throttle
module clk_enable_ctrl
    import clk_enable_ctrl_pkg::*;
#(
    parameter int DIV_W     = DEF_DIV_W,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input logic              clk,
    input logic              rst,
    clk_enable_ctrl_if.slave bus
);

    localparam logic [1:0] S_HALT = HALT;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_STEP = STEP;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [DIV_W-1:0] presc;
    logic             run_evt;
    logic             step_evt;
    logic             ce;
    logic             running_q;
    logic             halted_q;
    logic [15:0]      cnt_q;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_run_db (
        .clk (clk),
        .rst (rst),
        .btn (bus.run_btn),
        .evt (run_evt)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
        .clk (clk),
        .rst (rst),
        .btn (bus.step_btn),
        .evt (step_evt)
    );

    // leaving RUN masks the enable in the very cycle the stop is requested
    always_comb begin
        ce         = 1'b0;
        state_next = state;
        case (state)
            S_HALT: begin
                if (run_evt) begin
                    state_next = S_RUN;
                end else if (step_evt) begin
                    state_next = S_STEP;
                end
            end
            S_STEP: begin
                ce         = 1'b1;
                state_next = S_HALT;
            end
            S_RUN: begin
                if (bus.halt_req || run_evt) begin
                    state_next = S_HALT;
                end else begin
                    ce = !bus.mode_slow || (presc == bus.slow_div);
                end
            end
            default: state_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_HALT;
            presc     <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b1;
        end else begin
            state     <= state_next;
            running_q <= (state_next == S_RUN);
            halted_q  <= (state_next == S_HALT);
            if (ce) begin
                cnt_q <= cnt_q + 16'd1;
            end
            // a count past a freshly lowered slow_div wraps without a pulse
            if (state == S_RUN && state_next == S_RUN && bus.mode_slow) begin
                presc <= (presc >= bus.slow_div) ? '0 : presc + 1'b1;
            end else begin
                presc <= '0;
            end
        end
    end

    assign bus.cpu_ce    = ce;
    assign bus.running   = running_q;
    assign bus.halted    = halted_q;
    assign bus.cycle_cnt = cnt_q;

endmodule
